// File: rtl/bank_cmd_if.sv
// ---------------------------------------------------------------------------
// bank_cmd_if
//   Request handshake plus DDR command bus between a requester and the
//   single-bank command scheduler.
//
//   Requester -> scheduler : req_valid, req_write, req_row, req_col
//   Scheduler -> requester : req_ready, ACT, RD, WR, PR, REF, row, column,
//                            rd_done, wr_done, row_open
//
//   master modport : the requester / test side
//   slave  modport : the scheduler
// ---------------------------------------------------------------------------
interface bank_cmd_if #(
  parameter int ROW_W = 17,
  parameter int COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  logic             ACT;
  logic             RD;
  logic             WR;
  logic             PR;
  logic             REF;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] column;
  logic             rd_done;
  logic             wr_done;
  logic             row_open;

  modport master (
    output req_valid, req_write, req_row, req_col,
    input  req_ready, ACT, RD, WR, PR, REF, row, column,
           rd_done, wr_done, row_open
  );

  modport slave (
    input  req_valid, req_write, req_row, req_col,
    output req_ready, ACT, RD, WR, PR, REF, row, column,
           rd_done, wr_done, row_open
  );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// bank_cmd_scheduler
//   Single-bank command scheduler with an open-page policy. Accepts read and
//   write requests, issues correctly spaced one-hot ACT/RD/WR/PR/REF pulses,
//   inserts periodic refresh and reports completion TCL cycles after each
//   column command.
//
//   Ports
//     clk   : clock
//     rst   : synchronous active-high reset
//     halt  : freezes FSM, wait counter and refresh counter; masks pulses
//     bus   : bank_cmd_if.slave -- request handshake, command pulses,
//             row/column address, rd_done/wr_done, row_open
// ---------------------------------------------------------------------------
module bank_cmd_scheduler #(
  parameter int ROWS  = 131072,
  parameter int COLS  = 1024,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TCL   = 4,
  parameter int TRFC  = 8,
  parameter int TREFI = 64
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      halt,
  bank_cmd_if.slave bus
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int MAX_A  = (TRCD > TRP)  ? TRCD : TRP;
  localparam int MAX_B  = (TCL  > TRFC) ? TCL  : TRFC;
  localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int WAIT_W = (MAX_T > 2) ? $clog2(MAX_T) : 1;
  localparam int REF_W  = (TREFI > 2) ? $clog2(TREFI) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTWAIT,
    S_ACTIVE,
    S_CASWAIT,
    S_PREWAIT,
    S_REFWAIT
  } state_e;

  // One bit per single-cycle pulse; at most one of the command bits is set.
  typedef struct packed {
    logic act;
    logic rd;
    logic wr;
    logic pr;
    logic refresh;
    logic rd_done;
    logic wr_done;
  } pulse_t;

  state_e             state_q,       state_d;
  logic [WAIT_W-1:0]  wait_q,        wait_d;
  logic [REF_W-1:0]   ref_cnt_q,     ref_cnt_d;
  logic               ref_pending_q, ref_pending_d;
  logic               ref_mode_q,    ref_mode_d;     // PREWAIT leads to REF, not ACT
  logic               row_open_q,    row_open_d;
  logic [ROW_W-1:0]   row_q,         row_d;
  logic [COL_W-1:0]   column_q,      column_d;
  logic               lat_write_q,   lat_write_d;
  logic [ROW_W-1:0]   lat_row_q,     lat_row_d;
  logic [COL_W-1:0]   lat_col_q,     lat_col_d;
  pulse_t             pulse_q,       pulse_d;

  logic ready;
  logic accept;
  logic ref_wrap;

  // Reset is folded in so the handshake reads not-ready while rst is held.
  assign ready    = !rst && !halt && !ref_pending_q &&
                    (state_q == S_IDLE || state_q == S_ACTIVE);
  assign accept   = bus.req_valid && ready;
  assign ref_wrap = (ref_cnt_q == REF_W'(TREFI - 1));

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_d       = state_q;
    wait_d        = wait_q;
    ref_cnt_d     = ref_cnt_q;
    ref_pending_d = ref_pending_q;
    ref_mode_d    = ref_mode_q;
    row_open_d    = row_open_q;
    row_d         = row_q;
    column_d      = column_q;
    lat_write_d   = lat_write_q;
    lat_row_d     = lat_row_q;
    lat_col_d     = lat_col_q;
    pulse_d       = pulse_q;  // held through halt so a due pulse is not lost

    if (!halt) begin
      pulse_d   = '0;
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ref_pending_q) begin
            pulse_d.refresh = 1'b1;
            ref_pending_d   = 1'b0;
            wait_d          = WAIT_W'(TRFC - 1);
            state_d         = S_REFWAIT;
          end else if (accept) begin
            lat_write_d = bus.req_write;
            lat_row_d   = bus.req_row;
            lat_col_d   = bus.req_col;
            pulse_d.act = 1'b1;
            row_d       = bus.req_row;
            row_open_d  = 1'b1;
            wait_d      = WAIT_W'(TRCD - 1);
            state_d     = S_ACTWAIT;
          end
        end

        S_ACTWAIT: begin
          if (wait_q == '0) begin
            pulse_d.rd = !lat_write_q;
            pulse_d.wr = lat_write_q;
            column_d   = lat_col_q;
            wait_d     = WAIT_W'(TCL - 1);
            state_d    = S_CASWAIT;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end

        S_ACTIVE: begin
          if (ref_pending_q) begin
            pulse_d.pr = 1'b1;
            row_open_d = 1'b0;
            ref_mode_d = 1'b1;
            wait_d     = WAIT_W'(TRP - 1);
            state_d    = S_PREWAIT;
          end else if (accept) begin
            lat_write_d = bus.req_write;
            lat_row_d   = bus.req_row;
            lat_col_d   = bus.req_col;
            if (bus.req_row == row_q) begin
              pulse_d.rd = !bus.req_write;
              pulse_d.wr = bus.req_write;
              column_d   = bus.req_col;
              wait_d     = WAIT_W'(TCL - 1);
              state_d    = S_CASWAIT;
            end else begin
              pulse_d.pr = 1'b1;
              row_open_d = 1'b0;
              ref_mode_d = 1'b0;
              wait_d     = WAIT_W'(TRP - 1);
              state_d    = S_PREWAIT;
            end
          end
        end

        S_CASWAIT: begin
          if (wait_q == '0) begin
            pulse_d.rd_done = !lat_write_q;
            pulse_d.wr_done = lat_write_q;
            state_d         = S_ACTIVE;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end

        S_PREWAIT: begin
          if (wait_q == '0) begin
            if (ref_mode_q) begin
              pulse_d.refresh = 1'b1;
              ref_pending_d   = 1'b0;
              wait_d          = WAIT_W'(TRFC - 1);
              state_d         = S_REFWAIT;
            end else begin
              pulse_d.act = 1'b1;
              row_d       = lat_row_q;
              row_open_d  = 1'b1;
              wait_d      = WAIT_W'(TRCD - 1);
              state_d     = S_ACTWAIT;
            end
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end

        S_REFWAIT: begin
          if (wait_q == '0) begin
            state_d = S_IDLE;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase

      // Placed after the FSM so a wrap coinciding with REF issue still
      // leaves a refresh pending; repeated wraps collapse into one.
      if (ref_wrap) ref_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the values from before this edge.
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_mode_q    <= 1'b0;
      row_open_q    <= 1'b0;
      row_q         <= '0;
      column_q      <= '0;
      lat_write_q   <= 1'b0;
      lat_row_q     <= '0;
      lat_col_q     <= '0;
      pulse_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_mode_q    <= ref_mode_d;
      row_open_q    <= row_open_d;
      row_q         <= row_d;
      column_q      <= column_d;
      lat_write_q   <= lat_write_d;
      lat_row_q     <= lat_row_d;
      lat_col_q     <= lat_col_d;
      pulse_q       <= pulse_d;
    end
  end

  // Pulses are masked while halted; the flops keep them so they appear on
  // the first non-halted cycle.
  assign bus.ACT      = pulse_q.act     & ~halt;
  assign bus.RD       = pulse_q.rd      & ~halt;
  assign bus.WR       = pulse_q.wr      & ~halt;
  assign bus.PR       = pulse_q.pr      & ~halt;
  assign bus.REF      = pulse_q.refresh & ~halt;
  assign bus.rd_done  = pulse_q.rd_done & ~halt;
  assign bus.wr_done  = pulse_q.wr_done & ~halt;
  assign bus.row      = row_q;
  assign bus.column   = column_q;
  assign bus.row_open = row_open_q;
  assign bus.req_ready = ready;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
module tb_bank_cmd_scheduler;

  localparam int ROWS  = 131072;
  localparam int COLS  = 1024;
  localparam int TRCD  = 3;
  localparam int TRP   = 3;
  localparam int TCL   = 4;
  localparam int TRFC  = 8;
  localparam int TREFI = 64;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic halt = 1'b0;

  bank_cmd_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  bank_cmd_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .TRCD(TRCD), .TRP(TRP),
    .TCL(TCL), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int r0    = 0;  // first cycle after reset release (refresh counter = 0)

  typedef enum int {K_ACT, K_RD, K_WR, K_PR, K_REF, K_RDD, K_WRD} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    addr;
  } ev_t;

  ev_t sb[$];

  typedef struct {
    bit wr;
    int row;
    int col;
    int exp_acc;   // accept cycle relative to r0
    int pr;        // pulse offsets from accept, -1 = not expected
    int act;
    int cas;
    int done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void push_ev(input int c, input kind_e k, input int a);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    sb.push_back(e);
  endfunction

  function automatic void push_vec(input int t, input vec_t v);
    if (v.pr  >= 0) push_ev(t + v.pr,  K_PR,  0);
    if (v.act >= 0) push_ev(t + v.act, K_ACT, v.row);
    push_ev(t + v.cas,  v.wr ? K_WR  : K_RD,  v.col);
    push_ev(t + v.done, v.wr ? K_WRD : K_RDD, 0);
  endfunction

  function automatic longint all_outs();
    return longint'({bus.ACT, bus.RD, bus.WR, bus.PR, bus.REF, bus.rd_done,
                     bus.wr_done, bus.row_open, bus.req_ready, bus.row, bus.column});
  endfunction

  // Monitor: every observed pulse must be the next expected scoreboard event.
  always @(negedge clk) begin : mon
    logic [6:0] p;
    ev_t        e;
    p = {bus.wr_done, bus.rd_done, bus.REF, bus.PR, bus.WR, bus.RD, bus.ACT};
    check("cmd_onehot", longint'($countones(p[4:0]) > 1), 0);
    for (int i = 0; i < 7; i++) begin
      if (p[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", i, -1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", i, e.kind);
          check("pulse_cycle", cyc - r0, e.cyc - r0);
          if (i == K_ACT) check("act_row", bus.row, e.addr);
          if (i == K_RD || i == K_WR) check("cas_col", bus.column, e.addr);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    halt = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r0  = cyc;
  endtask

  task automatic goto_cycle(input int rel);
    while (cyc < r0 + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after accept.
  task automatic issue_req(input bit w, input int row, input int col, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_row   = ROW_W'(row);
    bus.req_col   = COL_W'(col);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        t   = cyc;
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!got) check("accept_timeout", got, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;

    //          wr row col acc  pr       act        cas             done
    vecs[0] = '{0, 5, 7, 10, -1,      1,      1 + TRCD,       1 + TRCD + TCL};
    vecs[1] = '{1, 5, 9, 18, -1,     -1,      1,              1 + TCL};
    vecs[2] = '{0, 6, 0, 23,  1, 1 + TRP, 1 + TRP + TRCD, 1 + TRP + TRCD + TCL};
    vecs[3] = '{0, 6, 3, 34, -1,     -1,      1,              1 + TCL};
    vecs[4] = '{1, 2, 1, 39,  1, 1 + TRP, 1 + TRP + TRCD, 1 + TRP + TRCD + TCL};

    // Reset state
    @(negedge clk);
    check("reset_outs", all_outs(), 0);
    do_reset();
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1);
    check("row_open_after_reset", bus.row_open, 0);

    // Table: idle read, hit write, miss read, hit read, miss write, back-to-back
    goto_cycle(10);
    for (int i = 0; i < 5; i++) begin
      issue_req(vecs[i].wr, vecs[i].row, vecs[i].col, t);
      check("accept_cycle", t - r0, vecs[i].exp_acc);
      push_vec(t, vecs[i]);
    end

    // Refresh wraps at cycle 63 with row 2 open; request waits behind it
    goto_cycle(64);
    push_ev(r0 + 65, K_PR, 0);
    push_ev(r0 + 65 + TRP, K_REF, 0);
    fork
      issue_req(1'b0, 9, 2, t);
      begin
        repeat (3) @(negedge clk);
        check("ref_row_open", bus.row_open, 0);
        check("ref_ready_low", bus.req_ready, 0);
      end
    join
    check("ref_accept_cycle", t - r0, 65 + TRP + TRFC);
    push_ev(t + 1, K_ACT, 9);
    push_ev(t + 1 + TRCD, K_RD, 2);
    push_ev(t + 1 + TRCD + TCL, K_RDD, 0);
    wait_drain(60);
    check("row_open_after_ref", bus.row_open, 1);

    // Halt: 5 cycles in ACTWAIT, then 1 cycle on the rd_done cycle
    do_reset();
    goto_cycle(2);
    issue_req(1'b0, 3, 4, t);
    check("halt_accept_cycle", t - r0, 2);
    push_ev(r0 + 3,  K_ACT, 3);
    push_ev(r0 + 11, K_RD,  4);
    push_ev(r0 + 16, K_RDD, 0);
    push_ev(r0 + 71, K_PR,  0);
    push_ev(r0 + 74, K_REF, 0);
    goto_cycle(4);
    halt = 1'b1;
    goto_cycle(9);
    halt = 1'b0;
    goto_cycle(15);
    halt = 1'b1;
    @(negedge clk);
    check("halt_ready_low", bus.req_ready, 0);
    goto_cycle(16);
    halt = 1'b0;
    @(negedge clk);
    check("ready_after_halt", bus.req_ready, 1);
    wait_drain(100);

    // Reset during CASWAIT
    do_reset();
    goto_cycle(2);
    issue_req(1'b0, 7, 1, t);
    check("rst_accept_cycle", t - r0, 2);
    push_ev(r0 + 3, K_ACT, 7);
    push_ev(r0 + 6, K_RD,  1);
    goto_cycle(7);
    rst = 1'b1;
    goto_cycle(8);
    check("pre_reset_sb", sb.size(), 0);
    @(negedge clk);
    check("rst_mid_outs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_pulse_after_rst", sb.size(), 0);
    check("row_open_after_rst", bus.row_open, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
